// File: rtl/vme_arb_pkg.sv
// Shared constants for the VME slot-1 bus arbiter: signal polarities, FSM states, arbitration modes.
package vme_arb_pkg;

  localparam logic ACTIVE   = 1'b0;
  localparam logic INACTIVE = 1'b1;

  localparam logic ARB_PRI = 1'b0;
  localparam logic ARB_RRS = 1'b1;

  localparam int NUM_LEVELS = 4;
  localparam int CNT_W      = 8;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GRANT = 2'd1,
    ARB_BUSY  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/vme_sync.sv
// Multi-stage synchronizer for asynchronous, active-low VME bus inputs; every stage resets to 1 (inactive).
module vme_sync #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [STAGES];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i] <= '1;
      end
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/vme_arbiter.sv
// VME system-controller bus arbiter: PRI or RRS selection, grant watchdog, optional bus-clear.
// Optional feature macro: VME_ARB_BCLR_EN (drives vme_bclr on competing requests while the bus is busy).
module vme_arbiter
  import vme_arb_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int GRANT_TIMEOUT = 64
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       arb_mode,
  input  logic [3:0] vme_br,
  input  logic       vme_bbsy,
  output logic [3:0] vme_bgout,
  output logic       vme_bclr,
  output logic [1:0] arb_owner,
  output logic       arb_busy,
  output logic       arb_timeout
);

  logic [4:0]       sync_q;
  logic [3:0]       br_s;
  logic             bbsy_s;
  arb_state_e       state_q, state_d;
  logic [3:0]       bgout_q, bgout_d;
  logic [1:0]       owner_q, owner_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tmo_q, tmo_d;
  logic [1:0]       winner;

  vme_sync #(
    .WIDTH (5),
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clock(clock),
    .reset(reset),
    .d_i  ({vme_bbsy, vme_br}),
    .q_o  (sync_q)
  );

  assign br_s   = sync_q[3:0];
  assign bbsy_s = sync_q[4];

  // req is active-high here; RRS searches downward from ptr-1, wrapping 0 -> 3.
  function automatic logic [1:0] select_winner(input logic [3:0] req, input logic mode,
                                               input logic [1:0] ptr);
    logic [1:0] win;
    logic [1:0] idx;
    logic       found;
    win   = 2'd0;
    idx   = 2'd0;
    found = 1'b0;
    if (mode == ARB_PRI) begin
      for (int i = 0; i < NUM_LEVELS; i++) begin
        if (req[i]) win = 2'(i);
      end
    end else begin
      for (int k = 1; k <= NUM_LEVELS; k++) begin
        idx = ptr - 2'(k);
        if (!found && req[idx]) begin
          win   = idx;
          found = 1'b1;
        end
      end
    end
    return win;
  endfunction

  assign winner = select_winner(~br_s, arb_mode, ptr_q);

  always_comb begin
    state_d = state_q;
    bgout_d = bgout_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    tmo_d   = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        if (bbsy_s == INACTIVE && br_s != 4'hF) begin
          state_d = ARB_GRANT;
          bgout_d = ~(4'b0001 << winner);
          owner_d = winner;
          cnt_d   = '0;
          if (arb_mode == ARB_RRS) ptr_d = winner;
        end
      end
      ARB_GRANT: begin
        if (bbsy_s == ACTIVE) begin
          state_d = ARB_BUSY;
          bgout_d = 4'hF;
        end else if (cnt_q == CNT_W'(GRANT_TIMEOUT - 1)) begin
          state_d = ARB_IDLE;
          bgout_d = 4'hF;
          tmo_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ARB_BUSY: begin
        if (bbsy_s == INACTIVE) state_d = ARB_IDLE;
      end
      default: begin
        state_d = ARB_IDLE;
        bgout_d = 4'hF;
      end
    endcase
  end

  // Grant lines come straight from flops so an async reset cannot glitch another level low.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ARB_IDLE;
      bgout_q <= 4'hF;
      owner_q <= 2'd0;
      ptr_q   <= 2'd3;
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bgout_q <= bgout_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
    end
  end

  assign vme_bgout   = bgout_q;
  assign arb_owner   = owner_q;
  assign arb_busy    = (state_q != ARB_IDLE);
  assign arb_timeout = tmo_q;

`ifdef VME_ARB_BCLR_EN
  logic       mode_q;
  logic       bclr_q, bclr_d;
  logic       competing;
  logic [3:0] req_act;

  // Competition is judged in the mode that issued the current tenure, latched while IDLE.
  always_comb begin
    req_act = ~br_s;
    if (mode_q == ARB_PRI) competing = |(req_act & (4'b1110 << owner_q));
    else                   competing = |(req_act & ~(4'b0001 << owner_q));
    bclr_d = INACTIVE;
    if (state_q == ARB_BUSY && bbsy_s == ACTIVE && (bclr_q == ACTIVE || competing)) begin
      bclr_d = ACTIVE;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mode_q <= ARB_PRI;
      bclr_q <= INACTIVE;
    end else begin
      bclr_q <= bclr_d;
      if (state_q == ARB_IDLE) mode_q <= arb_mode;
    end
  end

  assign vme_bclr = bclr_q;
`else
  assign vme_bclr = INACTIVE;
`endif

endmodule

// File: tb/tb_vme_arbiter.sv
// Directed and randomized bench for vme_arbiter, checked against a rule-level arbitration model.
module tb_vme_arbiter;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       arb_mode = 1'b0;
  logic [3:0] vme_br = 4'hF;
  logic       vme_bbsy = 1'b1;
  logic [3:0] vme_bgout;
  logic       vme_bclr;
  logic [1:0] arb_owner;
  logic       arb_busy;
  logic       arb_timeout;

  int vectors = 0;
  int miscompares = 0;
  int rrPtr = 3;

`ifdef VME_ARB_BCLR_EN
  localparam bit BCLR_EN = 1'b1;
`else
  localparam bit BCLR_EN = 1'b0;
`endif

  vme_arbiter #(
    .SYNC_STAGES  (2),
    .GRANT_TIMEOUT(64)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .arb_mode   (arb_mode),
    .vme_br     (vme_br),
    .vme_bbsy   (vme_bbsy),
    .vme_bgout  (vme_bgout),
    .vme_bclr   (vme_bclr),
    .arb_owner  (arb_owner),
    .arb_busy   (arb_busy),
    .arb_timeout(arb_timeout)
  );

  always #5 clock = ~clock;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic mode, input logic [3:0] br, input logic bbsy);
    arb_mode = mode;
    vme_br   = br;
    vme_bbsy = bbsy;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Winner from the arbitration rules: PRI = highest requesting level, RRS = first from ptr-1 downward.
  function automatic int expWinner(input logic [3:0] br, input logic mode, input int ptr);
    int w;
    w = -1;
    if (mode == 1'b0) begin
      for (int i = 3; i >= 0; i--) if (br[i] == 1'b0 && w < 0) w = i;
    end else begin
      for (int d = 1; d <= 4; d++) begin
        int idx;
        idx = (ptr + 4 - d) % 4;
        if (br[idx] == 1'b0 && w < 0) w = idx;
      end
    end
    return w;
  endfunction

  function automatic logic competingReq(input logic [3:0] br, input logic mode, input int owner);
    logic c;
    c = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (br[i] == 1'b0 && i != owner && (mode == 1'b1 || i > owner)) c = 1'b1;
    end
    return c;
  endfunction

  task automatic doReset();
    reset = 1'b0;
    applyStimulus(1'b0, 4'hF, 1'b1);
    tick(2);
    reset = 1'b1;
    rrPtr = 3;
    tick(2);
  endtask

  // One full tenure from a quiet IDLE: request, grant, claim via BBSY, release, settle.
  task automatic runTenure(input logic mode, input logic [3:0] req, output logic [1:0] obsOwner);
    int         w;
    logic [3:0] expG;
    logic       comp;
    w = expWinner(req, mode, rrPtr);
    expG = 4'hF;
    expG[w] = 1'b0;
    applyStimulus(mode, req, 1'b1);
    tick(2);
    checkOutput("latency_bg", 8'(vme_bgout), 8'hF);
    tick(1);
    checkOutput("grant_bg", 8'(vme_bgout), 8'(expG));
    checkOutput("grant_owner", 8'(arb_owner), 8'(w));
    checkOutput("grant_busy", 8'(arb_busy), 8'd1);
    obsOwner = arb_owner;
    if (mode) rrPtr = w;
    comp = competingReq(req, mode, w);
    applyStimulus(1'($urandom_range(0, 1)), req, 1'b0);
    tick(3);
    checkOutput("busy_bg", 8'(vme_bgout), 8'hF);
    checkOutput("busy_state", 8'(arb_busy), 8'd1);
    tick(1);
    checkOutput("busy_bclr", 8'(vme_bclr), 8'((BCLR_EN && comp) ? 1'b0 : 1'b1));
    applyStimulus(arb_mode, 4'hF, 1'b1);
    tick(3);
    checkOutput("idle_busy", 8'(arb_busy), 8'd0);
    checkOutput("idle_bclr", 8'(vme_bclr), 8'd1);
    checkOutput("idle_tmo", 8'(arb_timeout), 8'd0);
    tick(2);
  endtask

  initial begin
    logic [1:0] owner;
    logic [1:0] rrOrder [4];
    int         n;
    rrOrder = '{2'd2, 2'd1, 2'd0, 2'd3};

    $display("[TB] reset state");
    reset = 1'b0;
    applyStimulus(1'b0, 4'hF, 1'b1);
    tick(2);
    checkOutput("rst_bg", 8'(vme_bgout), 8'hF);
    checkOutput("rst_bclr", 8'(vme_bclr), 8'd1);
    checkOutput("rst_owner", 8'(arb_owner), 8'd0);
    checkOutput("rst_busy", 8'(arb_busy), 8'd0);
    checkOutput("rst_tmo", 8'(arb_timeout), 8'd0);
    reset = 1'b1;
    tick(2);

    $display("[TB] PRI BR3+BR1, then BR1 after one idle cycle");
    applyStimulus(1'b0, 4'b0101, 1'b1);
    tick(2);
    checkOutput("pri_latency", 8'(vme_bgout), 8'hF);
    tick(1);
    checkOutput("pri_bg", 8'(vme_bgout), 8'b0111);
    checkOutput("pri_owner", 8'(arb_owner), 8'd3);
    applyStimulus(1'b0, 4'b1101, 1'b0);
    tick(3);
    checkOutput("pri_busy_bg", 8'(vme_bgout), 8'hF);
    checkOutput("pri_busy", 8'(arb_busy), 8'd1);
    applyStimulus(1'b0, 4'b1101, 1'b1);
    tick(3);
    checkOutput("pri_idle_cycle_busy", 8'(arb_busy), 8'd0);
    checkOutput("pri_idle_cycle_bg", 8'(vme_bgout), 8'hF);
    tick(1);
    checkOutput("pri_next_bg", 8'(vme_bgout), 8'b1101);
    checkOutput("pri_next_owner", 8'(arb_owner), 8'd1);
    applyStimulus(1'b0, 4'hF, 1'b0);
    tick(3);
    applyStimulus(1'b0, 4'hF, 1'b1);
    tick(5);
    checkOutput("pri_end_busy", 8'(arb_busy), 8'd0);

    $display("[TB] foreign master holds BBSY");
    applyStimulus(1'b0, 4'hF, 1'b0);
    tick(4);
    checkOutput("foreign_busy", 8'(arb_busy), 8'd0);
    applyStimulus(1'b0, 4'b0111, 1'b0);
    tick(4);
    checkOutput("foreign_bg", 8'(vme_bgout), 8'hF);
    checkOutput("foreign_busy2", 8'(arb_busy), 8'd0);
    applyStimulus(1'b0, 4'b0111, 1'b1);
    tick(2);
    checkOutput("foreign_wait_bg", 8'(vme_bgout), 8'hF);
    tick(1);
    checkOutput("foreign_grant_bg", 8'(vme_bgout), 8'b0111);
    applyStimulus(1'b0, 4'hF, 1'b0);
    tick(3);
    applyStimulus(1'b0, 4'hF, 1'b1);
    tick(5);

    $display("[TB] bus clear: BR0 owns, BR2 arrives");
    applyStimulus(1'b0, 4'b1110, 1'b1);
    tick(3);
    checkOutput("bclr_owner", 8'(arb_owner), 8'd0);
    applyStimulus(1'b0, 4'b1110, 1'b0);
    tick(3);
    applyStimulus(1'b0, 4'b1010, 1'b0);
    tick(3);
    checkOutput("bclr_assert", 8'(vme_bclr), 8'(BCLR_EN ? 1'b0 : 1'b1));
    tick(3);
    checkOutput("bclr_hold", 8'(vme_bclr), 8'(BCLR_EN ? 1'b0 : 1'b1));
    applyStimulus(1'b0, 4'b1011, 1'b1);
    tick(2);
    checkOutput("bclr_hold_release", 8'(vme_bclr), 8'(BCLR_EN ? 1'b0 : 1'b1));
    tick(1);
    checkOutput("bclr_idle", 8'(vme_bclr), 8'd1);
    checkOutput("bclr_idle_busy", 8'(arb_busy), 8'd0);
    tick(1);
    checkOutput("bclr_next_bg", 8'(vme_bgout), 8'b1011);
    applyStimulus(1'b0, 4'hF, 1'b0);
    tick(3);
    applyStimulus(1'b0, 4'hF, 1'b1);
    tick(5);

    $display("[TB] watchdog on unclaimed BR0 grant");
    applyStimulus(1'b0, 4'b1110, 1'b1);
    tick(3);
    checkOutput("tmo_grant_bg", 8'(vme_bgout), 8'b1110);
    applyStimulus(1'b0, 4'hF, 1'b1);
    n = 0;
    while (n < 200 && vme_bgout !== 4'hF) begin
      tick(1);
      n++;
    end
    checkOutput("tmo_cycles", 8'(n), 8'd64);
    checkOutput("tmo_pulse", 8'(arb_timeout), 8'd1);
    checkOutput("tmo_busy", 8'(arb_busy), 8'd0);
    tick(1);
    checkOutput("tmo_pulse_end", 8'(arb_timeout), 8'd0);
    checkOutput("tmo_bg_end", 8'(vme_bgout), 8'hF);
    tick(2);

    $display("[TB] reset during GRANT");
    applyStimulus(1'b0, 4'b1011, 1'b1);
    tick(3);
    checkOutput("rstg_grant", 8'(vme_bgout), 8'b1011);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("rstg_bg", 8'(vme_bgout), 8'hF);
    checkOutput("rstg_busy", 8'(arb_busy), 8'd0);
    checkOutput("rstg_owner", 8'(arb_owner), 8'd0);
    doReset();

    $display("[TB] RRS all requests, four tenures");
    for (int i = 0; i < 4; i++) begin
      runTenure(1'b1, 4'b0000, owner);
      checkOutput("rr_order", 8'(owner), 8'(rrOrder[i]));
    end

    $display("[TB] randomized tenures");
    for (int i = 0; i < 40; i++) begin
      runTenure(1'($urandom_range(0, 1)), 4'($urandom_range(0, 14)), owner);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
